anim_sequencer: RTL and testbench

Parametrised animation sequencer between the SPI LCD driver and a sprite ROM. Holds NUM_ANIM animations of NUM_FRAMES full-screen frames each and plays the selected one, in loop or one-shot mode. Frame and animation changes are committed only at LCD frame boundaries (`frame_tick`), so the display never tears. It also serves pixel data for the driver's (x,y) scan through a fixed-latency pipeline.

---
 rtl/anim_sequencer_if.sv | 13 +
 rtl/anim_sequencer.sv | 130 +++++++++++++
 tb/tb_anim_sequencer.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/anim_sequencer_if.sv
// anim_sequencer_if: pixel request / sprite ROM bus between LCD driver, ROM and sequencer
interface anim_sequencer_if #(
  parameter int ROM_AW = 19,
  parameter int PIX_W  = 16
);
  logic [7:0]        pix_x;
  logic [7:0]        pix_y;
  logic [ROM_AW-1:0] rom_addr;
  logic [PIX_W-1:0]  rom_data;
  logic [PIX_W-1:0]  pix_data;
  modport master (output pix_x, pix_y, rom_data, input rom_addr, pix_data);
  modport slave  (input pix_x, pix_y, rom_data, output rom_addr, pix_data);
endinterface

// File: rtl/anim_sequencer.sv
// anim_sequencer: plays sprite-ROM animations, committing frame changes only on LCD frame ticks
module anim_sequencer #(
  parameter int              NUM_ANIM   = 4,
  parameter int              NUM_FRAMES = 4,
  parameter int              HOLD_TICKS = 8,
  parameter int              LCD_W      = 132,
  parameter int              LCD_H      = 162,
  parameter int              PIX_W      = 16,
  parameter logic [PIX_W-1:0] BG_COLOR  = 16'h0000,
  parameter int              ROM_AW     = $clog2(NUM_ANIM*NUM_FRAMES*LCD_W*LCD_H),
  parameter int              AW         = (NUM_ANIM > 1) ? $clog2(NUM_ANIM) : 1,
  parameter int              FW         = (NUM_FRAMES > 1) ? $clog2(NUM_FRAMES) : 1,
  parameter int              TW         = (HOLD_TICKS > 1) ? $clog2(HOLD_TICKS) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_go,
  input  logic [AW-1:0] i_anim_sel,
  input  logic          i_stop,
  input  logic          i_loop_en,
  input  logic          i_frame_tick,
  anim_sequencer_if.slave bus,
  output logic          o_busy,
  output logic          o_anim_done,
  output logic [AW-1:0] o_cur_anim,
  output logic [FW-1:0] o_cur_frame
);
  typedef enum logic [1:0] {IDLE, PLAY, HOLD} state_t;
  state_t        r_state, w_state_n;
  logic [AW-1:0] r_anim, w_anim_n, r_idx;
  logic [FW-1:0] r_frame, w_frame_n;
  logic [TW-1:0] r_hold, w_hold_n;
  logic          r_done, w_done_n;
  logic          r_go_d, r_stop_d, r_go_req, r_stop_req;
  logic          r_sel1, r_sel2;
  logic          w_go_rise, w_stop_rise, w_sel;
  assign w_go_rise   = i_go & ~r_go_d;
  assign w_stop_rise = i_stop & ~r_stop_d;
  assign w_sel       = (r_state != IDLE) && (32'(bus.pix_x) < LCD_W) && (32'(bus.pix_y) < LCD_H);
  assign o_busy      = r_state != IDLE;
  assign o_anim_done = r_done;
  assign o_cur_anim  = r_anim;
  assign o_cur_frame = r_frame;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_go_d     <= 1'b0;
      r_stop_d   <= 1'b0;
      r_go_req   <= 1'b0;
      r_stop_req <= 1'b0;
      r_idx      <= '0;
    end else begin
      r_go_d   <= i_go;
      r_stop_d <= i_stop;
      if (i_frame_tick) begin
        if (r_stop_req) r_stop_req <= 1'b0;
        else if (r_go_req) r_go_req <= 1'b0;
      end
      // edges arriving on a tick cycle override the clear and wait for the next tick
      if (w_stop_rise) begin
        r_stop_req <= 1'b1;
        r_go_req   <= 1'b0;
      end else if (w_go_rise && (32'(i_anim_sel) < NUM_ANIM)) begin
        r_go_req <= 1'b1;
        r_idx    <= i_anim_sel;
      end
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_anim  <= '0;
      r_frame <= '0;
      r_hold  <= '0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_n;
      r_anim  <= w_anim_n;
      r_frame <= w_frame_n;
      r_hold  <= w_hold_n;
      r_done  <= w_done_n;
    end
  end
  always_comb begin
    w_state_n = r_state;
    w_anim_n  = r_anim;
    w_frame_n = r_frame;
    w_hold_n  = r_hold;
    w_done_n  = 1'b0;
    if (i_frame_tick) begin
      if (r_stop_req) begin
        w_state_n = IDLE;
        w_anim_n  = '0;
        w_frame_n = '0;
        w_hold_n  = '0;
      end else if (r_go_req) begin
        w_state_n = PLAY;
        w_anim_n  = r_idx;
        w_frame_n = '0;
        w_hold_n  = '0;
      end else if (r_state == PLAY) begin
        if (32'(r_hold) == HOLD_TICKS - 1) begin
          w_hold_n = '0;
          if (32'(r_frame) == NUM_FRAMES - 1) begin
            w_done_n  = 1'b1;
            w_frame_n = i_loop_en ? '0 : r_frame;
            w_state_n = i_loop_en ? PLAY : HOLD;
          end else begin
            w_frame_n = r_frame + 1'b1;
          end
        end else begin
          w_hold_n = r_hold + 1'b1;
        end
      end
    end
  end
  // the select flag travels with the ROM read so pix_data lines up with rom_data
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.rom_addr <= '0;
      bus.pix_data <= BG_COLOR;
      r_sel1       <= 1'b0;
      r_sel2       <= 1'b0;
    end else begin
      bus.rom_addr <= w_sel ? ROM_AW'(((32'(r_anim)*NUM_FRAMES + 32'(r_frame))*LCD_H + 32'(bus.pix_y))*LCD_W + 32'(bus.pix_x)) : '0;
      r_sel1       <= w_sel;
      r_sel2       <= r_sel1;
      bus.pix_data <= r_sel2 ? bus.rom_data : BG_COLOR;
    end
  end
endmodule

// File: tb/tb_anim_sequencer.sv
// tb_anim_sequencer: directed scoreboard bench for the animation sequencer
module tb_anim_sequencer;
  typedef struct {string nm; int due; logic [31:0] val;} ent_t;
  logic clk = 1'b0, rst_n = 1'b0;
  logic go = 1'b0, stop = 1'b0, loop_en = 1'b1, tick = 1'b0;
  logic [1:0] sel = '0;
  logic busy, done, b3, d3;
  logic [1:0] anim, frame, a3, f3;
  int cyc = 0, n_cmp = 0, n_bad = 0;
  ent_t aq[$], pq[$], me;
  int dq[$];
  anim_sequencer_if #(.ROM_AW(19), .PIX_W(16)) bus ();
  anim_sequencer_if #(.ROM_AW(18), .PIX_W(16)) bus3 ();
  assign bus3.pix_x    = bus.pix_x;
  assign bus3.pix_y    = bus.pix_y;
  assign bus3.rom_data = 16'h0;
  anim_sequencer #(.NUM_ANIM(4), .NUM_FRAMES(4), .HOLD_TICKS(2)) dut (
    .clk(clk), .rst_n(rst_n), .i_go(go), .i_anim_sel(sel), .i_stop(stop), .i_loop_en(loop_en),
    .i_frame_tick(tick), .bus(bus), .o_busy(busy), .o_anim_done(done), .o_cur_anim(anim), .o_cur_frame(frame));
  anim_sequencer #(.NUM_ANIM(3), .NUM_FRAMES(4), .HOLD_TICKS(1)) dut3 (
    .clk(clk), .rst_n(rst_n), .i_go(go), .i_anim_sel(sel), .i_stop(stop), .i_loop_en(loop_en),
    .i_frame_tick(tick), .bus(bus3), .o_busy(b3), .o_anim_done(d3), .o_cur_anim(a3), .o_cur_frame(f3));
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  // synchronous sprite ROM model with address-dependent contents
  always @(posedge clk) bus.rom_data <= bus.rom_addr[15:0] ^ 16'h5A5A;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask
  task automatic ctl(input string nm, input bit b, input int a, input int f);
    chk(nm, {27'd0, busy, anim, frame}, {27'd0, b, a[1:0], f[1:0]});
  endtask
  task automatic do_tick(input bit exp_done);
    @(negedge clk) tick = 1'b1;
    if (exp_done) dq.push_back(cyc + 1);
    @(negedge clk) tick = 1'b0;
  endtask
  task automatic do_go(input int s);
    @(negedge clk) begin sel = s[1:0]; go = 1'b1; end
    @(negedge clk) go = 1'b0;
  endtask
  task automatic pix(input string nm, input int x, input int y, input bit act, input int a, input int f);
    ent_t e;
    logic [31:0] ad;
    bit on;
    @(negedge clk);
    bus.pix_x = x[7:0];
    bus.pix_y = y[7:0];
    on = act && x < 132 && y < 162;
    ad = on ? 32'(((a*4 + f)*162 + y)*132 + x) : 32'd0;
    e.nm = {nm, "_addr"}; e.due = cyc + 1; e.val = ad;
    aq.push_back(e);
    e.nm = {nm, "_pix"}; e.due = cyc + 3; e.val = on ? {16'd0, ad[15:0] ^ 16'h5A5A} : 32'd0;
    pq.push_back(e);
    repeat (4) @(negedge clk);
  endtask
  initial begin
    int lf[8] = '{0, 1, 1, 2, 2, 3, 3, 0};
    int of[8] = '{0, 1, 1, 2, 2, 3, 3, 3};
    bus.pix_x = '0;
    bus.pix_y = '0;
    fork
      forever begin
        @(posedge clk);
        #2;
        if (aq.size() > 0 && aq[0].due == cyc) begin me = aq.pop_front(); chk(me.nm, 32'(bus.rom_addr), me.val); end
        if (pq.size() > 0 && pq[0].due == cyc) begin me = pq.pop_front(); chk(me.nm, 32'(bus.pix_data), me.val); end
        if (done === 1'b1) begin
          if (dq.size() == 0) chk("done_unexpected", cyc, 32'hFFFF_FFFF);
          else chk("done_cycle", cyc, dq.pop_front());
        end
      end
      begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
      end
    join_none
    repeat (3) @(negedge clk);
    ctl("reset_ctl", 0, 0, 0);
    chk("reset_addr", 32'(bus.rom_addr), 0);
    chk("reset_pix", 32'(bus.pix_data), 0);
    chk("reset_done", 32'(done), 0);
    @(negedge clk) rst_n = 1'b1;
    pix("idle", 5, 0, 0, 0, 0);
    do_go(2);
    do_tick(0);
    ctl("start", 1, 2, 0);
    chk("start_h1", {27'd0, b3, a3, f3}, {27'd0, 1'b1, 2'd2, 2'd0});
    pix("p5_0", 5, 0, 1, 2, 0);
    pix("x_oob", 132, 0, 1, 2, 0);
    pix("y_oob", 0, 162, 1, 2, 0);
    for (int i = 0; i < 8; i++) begin
      do_tick(i == 7);
      ctl($sformatf("loop%0d", i), 1, 2, lf[i]);
      if (i < 3) chk($sformatf("h1_frame%0d", i), 32'(f3), i + 1);
    end
    @(negedge clk) loop_en = 1'b0;
    for (int i = 0; i < 8; i++) begin
      do_tick(i == 7);
      ctl($sformatf("oneshot%0d", i), 1, 2, of[i]);
    end
    for (int i = 0; i < 2; i++) begin
      do_tick(0);
      ctl($sformatf("hold%0d", i), 1, 2, 3);
    end
    pix("hold_pix", 10, 20, 1, 2, 3);
    do_go(1);
    do_tick(0);
    ctl("restart", 1, 1, 0);
    @(negedge clk) begin sel = 2'd2; go = 1'b1; stop = 1'b1; end
    @(negedge clk) begin go = 1'b0; stop = 1'b0; end
    do_tick(0);
    ctl("stop_go", 0, 0, 0);
    chk("stop_go_h1", 32'(b3), 0);
    pix("stopped", 5, 0, 0, 0, 0);
    do_tick(0);
    ctl("stop_nogo", 0, 0, 0);
    do_go(3);
    do_tick(0);
    chk("invalid_ignored", 32'(b3), 0);
    ctl("valid_main", 1, 3, 0);
    @(negedge clk) stop = 1'b1;
    @(negedge clk) stop = 1'b0;
    do_tick(0);
    ctl("stop2", 0, 0, 0);
    do_go(1);
    do_go(3);
    do_tick(0);
    ctl("latest", 1, 3, 0);
    do_tick(0);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    ctl("arst_ctl", 0, 0, 0);
    chk("arst_addr", 32'(bus.rom_addr), 0);
    chk("arst_pix", 32'(bus.pix_data), 0);
    chk("arst_done", 32'(done), 0);
    chk("arst_h1", 32'(b3), 0);
    @(negedge clk) rst_n = 1'b1;
    do_tick(0);
    do_tick(0);
    ctl("post_rst", 0, 0, 0);
    repeat (5) @(negedge clk);
    chk("done_left", dq.size(), 0);
    chk("addr_left", aq.size(), 0);
    chk("pix_left", pq.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
